// File: rtl/pipe_hazard_sched.sv
// -----------------------------------------------------------------------------
// pipe_hazard_sched
//
// Purpose: central hazard scheduler for a 5-stage MIPS pipeline. It resolves
// load-use bubbles, taken-branch/J flushes and multi-cycle mul/div occupancy
// stalls, and it keeps stall/flush statistics.
//
// Ports:
//   i_clk, i_rst_n        clock (rising edge), synchronous active-low reset
//   i_idex_memread        instruction in EX is a load
//   i_idex_rt             destination register of that load
//   i_ifid_rs/rt          source fields of the instruction in ID
//   i_ifid_uses_rt        ID instruction reads rt as a source
//   i_branch_taken        ID branch resolved taken
//   i_jump                ID instruction is J
//   i_md_start            ID instruction is mult/multu/div/divu
//   i_md_is_div           qualifies i_md_start: 1 = divide
//   o_pc_stall            hold PC
//   o_ifid_stall          hold IF/ID register
//   o_ifid_flush          zero IF/ID register (NOP)
//   o_idex_bubble         load a NOP into ID/EX
//   o_md_busy             mul/div sequence in progress
//   o_md_done             one-cycle pulse on the final mul/div cycle
//   o_stall_cnt           stall cycles since reset (wraps)
//   o_flush_cnt           flush events since reset (wraps)
//   o_dbg_state           current FSM state (0 = RUN, 1 = MD_BUSY)
//
// Handshake: i_md_start is a single-cycle request that is accepted in the
// cycle it is seen in RUN with no load-use hazard; the sequence ends with the
// one-cycle o_md_done pulse, after which the FSM is back in RUN.
// -----------------------------------------------------------------------------
module pipe_hazard_sched #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_idex_memread,
  input  logic [4:0]       i_idex_rt,
  input  logic [4:0]       i_ifid_rs,
  input  logic [4:0]       i_ifid_rt,
  input  logic             i_ifid_uses_rt,
  input  logic             i_branch_taken,
  input  logic             i_jump,
  input  logic             i_md_start,
  input  logic             i_md_is_div,
  output logic             o_pc_stall,
  output logic             o_ifid_stall,
  output logic             o_ifid_flush,
  output logic             o_idex_bubble,
  output logic             o_md_busy,
  output logic             o_md_done,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt,
  output logic             o_dbg_state
);

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_BUSY = 1'b1
  } state_t;

  // The issue cycle is one of the LAT cycles and the final busy cycle is the
  // one where the counter reads 0, hence the -2.
  localparam logic [7:0] MUL_INIT = 8'(MUL_LAT - 2);
  localparam logic [7:0] DIV_INIT = 8'(DIV_LAT - 2);

  state_t           r_state;
  logic [7:0]       r_md_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_load_use;
  logic w_md_issue;
  logic w_pc_stall;
  logic w_ifid_stall;
  logic w_ifid_flush;
  logic w_idex_bubble;
  logic w_md_busy;
  logic w_md_done;

  // $0 is hard-wired zero, so a load "into" it never creates a dependency.
  assign w_load_use = i_idex_memread && (i_idex_rt != 5'd0) &&
                      ((i_idex_rt == i_ifid_rs) ||
                       (i_ifid_uses_rt && (i_idex_rt == i_ifid_rt)));

  // Outputs respond in the same cycle as the hazard; reset forces them low.
  always_comb begin
    w_pc_stall    = 1'b0;
    w_ifid_stall  = 1'b0;
    w_ifid_flush  = 1'b0;
    w_idex_bubble = 1'b0;
    w_md_busy     = 1'b0;
    w_md_done     = 1'b0;
    w_md_issue    = 1'b0;
    if (i_rst_n) begin
      case (r_state)
        ST_RUN: begin
          if (w_load_use) begin
            // Operands not ready: branch/jump/md decisions wait a cycle.
            w_pc_stall    = 1'b1;
            w_ifid_stall  = 1'b1;
            w_idex_bubble = 1'b1;
          end else if (i_md_start) begin
            // Let the mul/div flow into ID/EX this cycle.
            w_md_issue = 1'b1;
          end else if (i_branch_taken || i_jump) begin
            w_ifid_flush = 1'b1;
          end
        end
        ST_MD_BUSY: begin
          w_md_busy     = 1'b1;
          w_pc_stall    = 1'b1;
          w_ifid_stall  = 1'b1;
          w_idex_bubble = 1'b1;
          w_md_done     = (r_md_cnt == 8'd0);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_RUN;
      r_md_cnt    <= 8'd0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, w_pc_stall};
      r_flush_cnt <= r_flush_cnt + {{(CNT_W-1){1'b0}}, w_ifid_flush};
      case (r_state)
        ST_RUN: begin
          if (w_md_issue) begin
            r_state  <= ST_MD_BUSY;
            r_md_cnt <= i_md_is_div ? DIV_INIT : MUL_INIT;
          end
        end
        ST_MD_BUSY: begin
          if (r_md_cnt == 8'd0) begin
            r_state <= ST_RUN;
          end else begin
            r_md_cnt <= r_md_cnt - 8'd1;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign o_pc_stall    = w_pc_stall;
  assign o_ifid_stall  = w_ifid_stall;
  assign o_ifid_flush  = w_ifid_flush;
  assign o_idex_bubble = w_idex_bubble;
  assign o_md_busy     = w_md_busy;
  assign o_md_done     = w_md_done;
  assign o_stall_cnt   = r_stall_cnt;
  assign o_flush_cnt   = r_flush_cnt;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_pipe_hazard_sched.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_sched
//
// Directed bench for pipe_hazard_sched. Each stimulus step pushes the
// hand-derived control vector {pc_stall, ifid_stall, ifid_flush, idex_bubble,
// md_busy, md_done} plus the counter values expected in that cycle; a
// monitor samples the DUT on the falling edge and compares against the queue.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_sched;

  localparam int CNT_W = 32;
  localparam int W     = 6 + 2 * CNT_W;

  // Control vector encodings
  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] STL  = 6'b110100;
  localparam logic [5:0] FLS  = 6'b001000;
  localparam logic [5:0] BSY  = 6'b110110;
  localparam logic [5:0] DON  = 6'b110111;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             idex_memread;
  logic [4:0]       idex_rt, ifid_rs, ifid_rt;
  logic             ifid_uses_rt, branch_taken, jump, md_start, md_is_div;
  logic             pc_stall, ifid_stall, ifid_flush, idex_bubble;
  logic             md_busy, md_done, dbg_state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipe_hazard_sched #(.MUL_LAT(4), .DIV_LAT(16), .CNT_W(CNT_W)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_idex_memread (idex_memread),
    .i_idex_rt      (idex_rt),
    .i_ifid_rs      (ifid_rs),
    .i_ifid_rt      (ifid_rt),
    .i_ifid_uses_rt (ifid_uses_rt),
    .i_branch_taken (branch_taken),
    .i_jump         (jump),
    .i_md_start     (md_start),
    .i_md_is_div    (md_is_div),
    .o_pc_stall     (pc_stall),
    .o_ifid_stall   (ifid_stall),
    .o_ifid_flush   (ifid_flush),
    .o_idex_bubble  (idex_bubble),
    .o_md_busy      (md_busy),
    .o_md_done      (md_done),
    .o_stall_cnt    (stall_cnt),
    .o_flush_cnt    (flush_cnt),
    .o_dbg_state    (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           total = 0;
  int           bad   = 0;
  logic [CNT_W-1:0] m_stall = '0;
  logic [CNT_W-1:0] m_flush = '0;

  // ---------------- driver tasks ----------------
  task automatic step(input string tag, input logic rn, input logic mr,
                      input logic [4:0] xrt, input logic [4:0] rs,
                      input logic [4:0] rt, input logic urt, input logic br,
                      input logic jp, input logic ms, input logic md,
                      input logic [5:0] exp_ctl, input logic chk);
    @(posedge clk);
    #1;
    rst_n = rn; idex_memread = mr; idex_rt = xrt; ifid_rs = rs;
    ifid_rt = rt; ifid_uses_rt = urt; branch_taken = br; jump = jp;
    md_start = ms; md_is_div = md;
    if (chk) begin
      exp_q.push_back({exp_ctl, m_stall, m_flush});
      tag_q.push_back(tag);
    end
    // Counters are registered: this cycle's event shows up next cycle.
    if (!rn) begin
      m_stall = '0;
      m_flush = '0;
    end else begin
      m_stall = m_stall + {{(CNT_W-1){1'b0}}, exp_ctl[5]};
      m_flush = m_flush + {{(CNT_W-1){1'b0}}, exp_ctl[3]};
    end
  endtask

  task automatic idle(input string tag, input logic [5:0] exp_ctl);
    step(tag, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
         exp_ctl, 1'b1);
  endtask

  task automatic busy_br(input string tag, input int n, input logic br);
    for (int i = 1; i <= n; i++)
      step(tag, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, br, 1'b0, 1'b0, 1'b0,
           (i == n) ? DON : BSY, 1'b1);
  endtask

  task automatic rand_reset(input string tag, input logic chk);
    step(tag, 1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
         5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         1'($urandom_range(0, 1)), NONE, chk);
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [W-1:0] got, e;
    string t;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        got = {pc_stall, ifid_stall, ifid_flush, idex_bubble, md_busy,
               md_done, stall_cnt, flush_cnt};
        total++;
        if (got !== e) begin
          bad++;
          $display("FAIL %s: ctl got=%b exp=%b stall_cnt got=%0d exp=%0d flush_cnt got=%0d exp=%0d",
                   t, got[W-1 -: 6], e[W-1 -: 6],
                   got[2*CNT_W-1 -: CNT_W], e[2*CNT_W-1 -: CNT_W],
                   got[CNT_W-1:0], e[CNT_W-1:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; idex_memread = 1'b0; idex_rt = 5'd0; ifid_rs = 5'd0;
    ifid_rt = 5'd0; ifid_uses_rt = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    md_start = 1'b0; md_is_div = 1'b0;

    // Reset with random inputs; counters are unknown before the first edge.
    rand_reset("reset_c1", 1'b0);
    rand_reset("reset_c2", 1'b1);
    idle("post_reset", NONE);

    // Load-use on rs
    step("lu_rs", 1, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0, 0, STL, 1);
    step("lu_rs_after", 1, 0, 5'd0, 5'd5, 5'd0, 0, 0, 0, 0, 0, NONE, 1);
    // $0 never stalls; rt match without uses_rt never stalls
    step("lu_r0", 1, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0, NONE, 1);
    step("lu_rt_unused", 1, 1, 5'd7, 5'd3, 5'd7, 0, 0, 0, 0, 0, NONE, 1);
    step("lu_rt_used", 1, 1, 5'd7, 5'd3, 5'd7, 1, 0, 0, 0, 0, STL, 1);

    // Load-use plus taken branch: stall first, flush once hazard clears
    step("lu_br_c1", 1, 1, 5'd5, 5'd0, 5'd5, 1, 1, 0, 0, 0, STL, 1);
    step("lu_br_c2", 1, 0, 5'd0, 5'd0, 5'd5, 1, 1, 0, 0, 0, FLS, 1);
    idle("lu_br_after", NONE);

    // Branch and jump together count as one flush
    step("br_jump", 1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, 0, FLS, 1);
    step("jump_only", 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, FLS, 1);
    idle("flush_after", NONE);

    // Divide issued with a taken branch present: md_start wins, then 15 busy
    // cycles with the branch held, then the branch flushes in RUN.
    step("div_issue", 1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1, 1, NONE, 1);
    busy_br("div_busy", 15, 1'b1);
    step("div_br_run", 1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0, FLS, 1);
    idle("div_after", NONE);

    // Back-to-back multiplies: 3 busy cycles each, one RUN cycle between
    step("mul1_issue", 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, NONE, 1);
    busy_br("mul1_busy", 3, 1'b0);
    step("mul2_issue", 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, NONE, 1);
    busy_br("mul2_busy", 3, 1'b0);
    idle("mul_after", NONE);

    // Load-use has priority over md_start; the mult issues next cycle
    step("lu_over_md", 1, 1, 5'd9, 5'd9, 5'd0, 0, 0, 0, 1, 0, STL, 1);
    step("md_after_lu", 1, 0, 5'd0, 5'd9, 5'd0, 0, 0, 0, 1, 0, NONE, 1);
    busy_br("mul3_busy", 3, 1'b0);
    idle("mul3_after", NONE);

    // Reset in the 7th busy cycle of a divide: no done pulse, counters clear
    step("div2_issue", 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, NONE, 1);
    for (int i = 0; i < 6; i++) idle("div2_busy", BSY);
    step("div2_reset", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, NONE, 1);
    idle("div2_post_rst", NONE);
    step("post_rst_br", 1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0, FLS, 1);
    idle("final", NONE);

    // Drain: bounded wait for the monitor to consume the queue
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: pending=%0d required=0", exp_q.size());
    end
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_sched.md
Name: pipe_hazard_sched

Overview:
- Central hazard scheduler for the 5-stage MIPS pipeline.
- Replaces the purely combinational branch/jump flush logic with a sequenced controller. It resolves four hazard classes per cycle:
  - load-use data hazards (1-cycle bubble),
  - taken branch (bne/beq/bgez/bgtz/blez/bltz) and J flushes,
  - multi-cycle mul/div occupancy stalls,
  - statistics counting.
- Sits between ID decode, the ID/EX register and the PC/IF-ID pipeline registers.

Parameters:
- MUL_LAT, 4, EX-stage cycles occupied by mult/multu (range 2..255).
- DIV_LAT, 16, EX-stage cycles occupied by div/divu (range 2..255).
- CNT_W, 32, width of the stall and flush statistic counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  synchronous reset, active low.
- idex_memread  in  1  instruction in EX is a load.
- idex_rt  in  5  destination register of the EX load.
- ifid_rs  in  5  rs field of the instruction in ID.
- ifid_rt  in  5  rt field of the instruction in ID.
- ifid_uses_rt  in  1  ID instruction reads rt as a source.
- branch_taken  in  1  ID branch condition resolved as taken.
- jump  in  1  ID instruction is J.
- md_start  in  1  ID instruction is mult/multu/div/divu.
- md_is_div  in  1  qualifies md_start: 1 = divide.
- pc_stall  out  1  hold PC.
- ifid_stall  out  1  hold the IF/ID register.
- ifid_flush  out  1  zero the IF/ID register (NOP).
- idex_bubble  out  1  load a NOP into ID/EX.
- md_busy  out  1  mul/div sequence in progress.
- md_done  out  1  one-cycle pulse on the final mul/div cycle.
- stall_cnt  out  CNT_W  total stall cycles since reset.
- flush_cnt  out  CNT_W  total flush events since reset.

Behaviour:
- Clock and reset:
  - One clock; reset is synchronous and active-low.
  - rst_n=0 at a rising edge sets state=RUN, md_cnt=0, stall_cnt=0 and flush_cnt=0.
  - While rst_n=0, all control outputs are forced to 0.
  - Reset mid-mul/div aborts the sequence with no md_done pulse.
- Load-use hazard:
  - load_use = idex_memread & idex_rt!=0 & (idex_rt==ifid_rs | (ifid_uses_rt & idex_rt==ifid_rt)).
- Output timing: all control outputs are combinational from the registered state plus the current-cycle inputs, so the response appears in the same cycle as the hazard.
- State RUN, priority highest first:
  1. load_use: pc_stall=1, ifid_stall=1, idex_bubble=1 for exactly one cycle.
     - branch_taken, jump and md_start are ignored that cycle, because operands are not ready.
     - The instruction re-presents next cycle.
  2. md_start: all outputs 0 this cycle, so the mul/div enters ID/EX.
     - Next state MD_BUSY, with md_cnt = (md_is_div ? DIV_LAT : MUL_LAT) - 2.
  3. branch_taken or jump: ifid_flush=1 and pc_stall=0 for one cycle, so the PC loads the target. Both asserted together count as one flush.
  4. Otherwise all outputs 0.
- State MD_BUSY:
  - md_busy=1, pc_stall=1, ifid_stall=1, idex_bubble=1 every cycle.
  - All ID inputs are ignored, so a branch waiting in ID is not flushed.
  - md_cnt decrements each cycle.
  - When md_cnt==0: md_done=1 that cycle, and next state is RUN.
  - Total occupancy is the latency parameter: 1 issue cycle plus (LAT-1) busy cycles.
- Counters:
  - stall_cnt increments each cycle pc_stall=1.
  - flush_cnt increments each cycle ifid_flush=1.
  - Both wrap modulo 2^CNT_W and are registered, so each value updates on the edge after its event.
- Register $0: idex_rt==0 never produces a load-use stall.

Test Plan:
- Reset: rst_n=0 for 2 cycles with random inputs -> all outputs 0, stall_cnt=0, flush_cnt=0.
- Load-use: lw $5 in EX (idex_memread=1, idex_rt=5), add in ID with ifid_rs=5 -> one cycle of pc_stall=ifid_stall=idex_bubble=1, then 0; stall_cnt=1.
- Load-use plus taken branch: idex_rt=5, ifid_rt=5, ifid_uses_rt=1, branch_taken=1 in the same cycle -> cycle 1 stall only with ifid_flush=0; with the hazard gone in cycle 2, ifid_flush=1; flush_cnt=1.
- Divide: md_start=1, md_is_div=1, DIV_LAT=16 -> 15 cycles of md_busy=1 with stalls; md_done=1 on the 15th; branch_taken held high throughout produces no flush until RUN.
- Multiply back-to-back: two mult instructions with MUL_LAT=4 -> busy windows of 3 cycles each with one RUN cycle between them; stall_cnt=6.
- Reset mid-divide: rst_n=0 at busy cycle 7 -> next cycle state RUN, md_busy=0, no md_done pulse, counters 0.
